// File: rtl/elelock_pkg.sv
// Shared types and helpers for the electronic lock controller.
package elelock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    NEWPIN  = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } key_t;

  // One-hot key pattern to digit; anything not exactly one-hot is invalid.
  function automatic key_t keyenc(input logic [9:0] keys);
    key_t        res;
    int unsigned n_set;
    res.valid = 1'b0;
    res.digit = BLANK_DIGIT;
    n_set     = 0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) begin
        n_set     = n_set + 1;
        res.digit = 4'(i);
      end
    end
    res.valid = (n_set == 1);
    if (!res.valid) res.digit = BLANK_DIGIT;
    return res;
  endfunction

endpackage

// File: rtl/elelock_if.sv
// Keypad/door inputs and lock status outputs of the lock controller.
interface elelock_if;
  logic [9:0] tenkey;
  logic       enter;
  logic       close;
  logic       setpin;
  logic       lock;
  logic       alarm;
  logic [2:0] state;
  logic [2:0] digit_cnt;
  logic [2:0] fail_cnt;

  modport master (
    output tenkey, enter, close, setpin,
    input  lock, alarm, state, digit_cnt, fail_cnt
  );

  modport slave (
    input  tenkey, enter, close, setpin,
    output lock, alarm, state, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/elelock_keyin.sv
// Key press edge detector and digit encoder for the ten-key pad.
module elelock_keyin
  import elelock_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] tenkey_i,
  output logic       key_evt_o,
  output logic [3:0] digit_o,
  output logic       kd_valid_o
);

  logic ke1_q, ke2_q;
  key_t kd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ke1_q <= 1'b0;
      ke2_q <= 1'b0;
      kd_q  <= {1'b0, BLANK_DIGIT};
    end else begin
      ke1_q <= |tenkey_i;
      ke2_q <= ke1_q;
      kd_q  <= keyenc(tenkey_i);
    end
  end

  assign key_evt_o  = ke1_q & ~ke2_q;
  assign digit_o    = kd_q.digit;
  assign kd_valid_o = kd_q.valid;

endmodule

// File: rtl/elelock_ctrl.sv
// PIN entry, compare, lockout and PIN-change sequencer driving the lock actuator.
module elelock_ctrl
  import elelock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PIN = 16'h5963,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned LOCKOUT_CYC = 5000
) (
  input logic      ck,
  input logic      reset_n,
  elelock_if.slave bus
);

  localparam int unsigned TMAX = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [15:0] BLANK_BUF = {4{BLANK_DIGIT}};

  state_t          state_q, state_d;
  logic [15:0]     buf_q, buf_d, pin_q, pin_d;
  logic [2:0]      cnt_q, cnt_d, fail_q, fail_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            lock_q, lock_d, alarm_q, alarm_d;
  logic            key_evt, kd_valid, key_ok;
  logic [3:0]      digit;
  logic [15:0]     shift_buf;
  logic [2:0]      shift_cnt;
  logic            pin_match, last_fail, time_out, lock_done;

  elelock_keyin u_keyin (
    .clk_i      (ck),
    .rst_ni     (reset_n),
    .tenkey_i   (bus.tenkey),
    .key_evt_o  (key_evt),
    .digit_o    (digit),
    .kd_valid_o (kd_valid)
  );

  assign key_ok    = key_evt & kd_valid;
  assign shift_buf = {buf_q[11:0], digit};
  assign shift_cnt = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
  assign pin_match = (cnt_q == 3'd4) && (buf_q == pin_q);
  assign last_fail = ({29'd0, fail_q} + 32'd1) == MAX_FAIL;
  assign time_out  = tmr_q >= TW'(TIMEOUT_CYC - 1);
  assign lock_done = tmr_q >= TW'(LOCKOUT_CYC - 1);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    pin_d   = pin_q;
    tmr_d   = (tmr_q == TW'(TMAX)) ? tmr_q : tmr_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.close) begin
          buf_d = BLANK_BUF;
          cnt_d = 3'd0;
        end else if (key_ok) begin
          state_d = ENTRY;
          buf_d   = {BLANK_BUF[15:4], digit};
          cnt_d   = 3'd1;
        end
      end
      ENTRY: begin
        if (bus.close) begin
          state_d = IDLE;
          buf_d   = BLANK_BUF;
          cnt_d   = 3'd0;
        end else if (bus.enter) begin
          if (pin_match) begin
            state_d = OPEN;
            fail_d  = 3'd0;
          end else begin
            state_d = last_fail ? LOCKOUT : IDLE;
            fail_d  = fail_q + 3'd1;
            buf_d   = BLANK_BUF;
            cnt_d   = 3'd0;
          end
        end else if (key_ok) begin
          buf_d = shift_buf;
          cnt_d = shift_cnt;
          tmr_d = '0;
        end else if (time_out) begin
          state_d = IDLE;
          buf_d   = BLANK_BUF;
          cnt_d   = 3'd0;
        end
      end
      OPEN: begin
        if (bus.close) begin
          state_d = IDLE;
          buf_d   = BLANK_BUF;
          cnt_d   = 3'd0;
        end else if (bus.setpin) begin
          state_d = NEWPIN;
          buf_d   = BLANK_BUF;
          cnt_d   = 3'd0;
        end
      end
      NEWPIN: begin
        if (bus.close) begin
          state_d = IDLE;
          buf_d   = BLANK_BUF;
          cnt_d   = 3'd0;
        end else if (bus.enter || (!key_ok && time_out)) begin
          // Only a complete 4-digit entry replaces the PIN.
          if (bus.enter && cnt_q == 3'd4) pin_d = buf_q;
          state_d = OPEN;
          buf_d   = BLANK_BUF;
          cnt_d   = 3'd0;
        end else if (key_ok) begin
          buf_d = shift_buf;
          cnt_d = shift_cnt;
          tmr_d = '0;
        end
      end
      LOCKOUT: begin
        if (lock_done) begin
          state_d = IDLE;
          fail_d  = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        buf_d   = BLANK_BUF;
        cnt_d   = 3'd0;
      end
    endcase
    if (state_d != state_q) tmr_d = '0;
    lock_d  = !((state_d == OPEN) || (state_d == NEWPIN));
    alarm_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= BLANK_BUF;
      cnt_q   <= 3'd0;
      fail_q  <= 3'd0;
      pin_q   <= DEFAULT_PIN;
      tmr_q   <= '0;
      lock_q  <= 1'b1;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      pin_q   <= pin_d;
      tmr_q   <= tmr_d;
      lock_q  <= lock_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.lock      = lock_q;
  assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Self-checking bench for elelock_ctrl: cycle vectors, corner sequences, random vs model.
module tb_elelock_ctrl;
  import elelock_pkg::*;

  localparam int MAX_FAIL    = 3;
  localparam int TIMEOUT_CYC = 1000;
  localparam int LOCKOUT_CYC = 5000;

  logic ck;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   acc_cyc;
  int   ev_cyc;

  elelock_if bus ();

  elelock_ctrl #(
    .DEFAULT_PIN (16'h5963),
    .MAX_FAIL    (MAX_FAIL),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .ck      (ck),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] tk;
    logic       en;
    logic       cl;
    logic       sp;
    state_t     st;
    logic       lk;
    logic [2:0] cnt;
    logic [2:0] fl;
  } vec_t;

  vec_t vecs[22];

  // Transaction-level reference: entry as a digit queue, PIN as a digit array.
  int m_st;
  int m_q[$];
  int m_fail;
  int m_pin[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    bus.tenkey = '0;
    bus.enter  = 1'b0;
    bus.close  = 1'b0;
    bus.setpin = 1'b0;
    reset_n    = 1'b0;
    repeat (2) @(negedge ck);
    reset_n = 1'b1;
  endtask

  task automatic press_raw(input logic [9:0] v, input int hold);
    bus.tenkey = v;
    for (int i = 0; i < hold; i++) begin
      @(negedge ck);
      if (i == 1) acc_cyc = cyc;
    end
    bus.tenkey = '0;
    repeat (3) @(negedge ck);
  endtask

  task automatic press(input int d);
    logic [9:0] v;
    v = 10'd1 << d;
    press_raw(v, 2 + int'($urandom_range(0, 2)));
  endtask

  task automatic pulse(input int which);
    if (which == 0) bus.enter = 1'b1;
    else if (which == 1) bus.close = 1'b1;
    else bus.setpin = 1'b1;
    @(negedge ck);
    ev_cyc     = cyc;
    bus.enter  = 1'b0;
    bus.close  = 1'b0;
    bus.setpin = 1'b0;
    repeat (2) @(negedge ck);
  endtask

  task automatic pin4(input int a, input int b, input int c, input int d);
    press(a);
    press(b);
    press(c);
    press(d);
    pulse(0);
  endtask

  function automatic bit m_match();
    if (m_q.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_q[i] != m_pin[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_init();
    m_st   = int'(IDLE);
    m_fail = 0;
    m_q.delete();
    m_pin = '{5, 9, 6, 3};
  endtask

  task automatic m_press(input int d);
    if (m_st == int'(IDLE)) begin
      m_st = int'(ENTRY);
      m_q.delete();
      m_q.push_back(d);
    end else if (m_st == int'(ENTRY) || m_st == int'(NEWPIN)) begin
      m_q.push_back(d);
      if (m_q.size() > 4) void'(m_q.pop_front());
    end
  endtask

  task automatic m_enter();
    if (m_st == int'(ENTRY)) begin
      if (m_match()) begin
        m_st   = int'(OPEN);
        m_fail = 0;
      end else begin
        m_fail++;
        m_q.delete();
        m_st = (m_fail == MAX_FAIL) ? int'(LOCKOUT) : int'(IDLE);
      end
    end else if (m_st == int'(NEWPIN)) begin
      if (m_q.size() == 4) for (int i = 0; i < 4; i++) m_pin[i] = m_q[i];
      m_q.delete();
      m_st = int'(OPEN);
    end
  endtask

  task automatic m_close();
    if (m_st != int'(LOCKOUT)) begin
      m_st = int'(IDLE);
      m_q.delete();
    end
  endtask

  task automatic m_setpin();
    if (m_st == int'(OPEN)) begin
      m_st = int'(NEWPIN);
      m_q.delete();
    end
  endtask

  task automatic check_model();
    int exp_lock;
    exp_lock = (m_st == int'(OPEN) || m_st == int'(NEWPIN)) ? 0 : 1;
    chk("rand_state", int'(bus.state), m_st);
    chk("rand_lock", int'(bus.lock), exp_lock);
    chk("rand_alarm", int'(bus.alarm), (m_st == int'(LOCKOUT)) ? 1 : 0);
    chk("rand_fail", int'(bus.fail_cnt), m_fail);
    if (m_st != int'(OPEN)) chk("rand_cnt", int'(bus.digit_cnt), m_q.size());
  endtask

  initial begin
    int lk_cyc;
    checks = 0;
    errors = 0;
    acc_cyc = 0;
    ev_cyc = 0;

    vecs[0]  = '{10'h020, 0, 0, 0, IDLE,  1, 0, 0};
    vecs[1]  = '{10'h000, 0, 0, 0, ENTRY, 1, 1, 0};
    vecs[2]  = '{10'h200, 0, 0, 0, ENTRY, 1, 1, 0};
    vecs[3]  = '{10'h000, 0, 0, 0, ENTRY, 1, 2, 0};
    vecs[4]  = '{10'h040, 0, 0, 0, ENTRY, 1, 2, 0};
    vecs[5]  = '{10'h000, 0, 0, 0, ENTRY, 1, 3, 0};
    vecs[6]  = '{10'h008, 0, 0, 0, ENTRY, 1, 3, 0};
    vecs[7]  = '{10'h000, 0, 0, 0, ENTRY, 1, 4, 0};
    vecs[8]  = '{10'h000, 1, 0, 0, OPEN,  0, 4, 0};
    vecs[9]  = '{10'h000, 0, 1, 0, IDLE,  1, 0, 0};
    vecs[10] = '{10'h021, 0, 0, 0, IDLE,  1, 0, 0};
    vecs[11] = '{10'h000, 0, 0, 0, IDLE,  1, 0, 0};
    vecs[12] = '{10'h002, 0, 0, 0, IDLE,  1, 0, 0};
    vecs[13] = '{10'h000, 0, 0, 0, ENTRY, 1, 1, 0};
    vecs[14] = '{10'h021, 0, 0, 0, ENTRY, 1, 1, 0};
    vecs[15] = '{10'h000, 0, 0, 0, ENTRY, 1, 1, 0};
    vecs[16] = '{10'h004, 0, 0, 0, ENTRY, 1, 1, 0};
    vecs[17] = '{10'h000, 1, 0, 0, IDLE,  1, 0, 1};
    vecs[18] = '{10'h020, 0, 0, 0, IDLE,  1, 0, 1};
    vecs[19] = '{10'h000, 0, 0, 0, ENTRY, 1, 1, 1};
    vecs[20] = '{10'h200, 0, 0, 0, ENTRY, 1, 1, 1};
    vecs[21] = '{10'h000, 0, 1, 0, IDLE,  1, 0, 1};

    // Reset state
    bus.tenkey = '0;
    bus.enter  = 1'b0;
    bus.close  = 1'b0;
    bus.setpin = 1'b0;
    reset_n    = 1'b0;
    repeat (2) @(negedge ck);
    chk("rst_state", int'(bus.state), int'(IDLE));
    chk("rst_lock", int'(bus.lock), 1);
    chk("rst_alarm", int'(bus.alarm), 0);
    chk("rst_cnt", int'(bus.digit_cnt), 0);
    chk("rst_fail", int'(bus.fail_cnt), 0);
    reset_n = 1'b1;

    // Cycle-accurate vectors: inputs before edge i, outputs after edge i
    for (int i = 0; i < 22; i++) begin
      bus.tenkey = vecs[i].tk;
      bus.enter  = vecs[i].en;
      bus.close  = vecs[i].cl;
      bus.setpin = vecs[i].sp;
      @(negedge ck);
      chk($sformatf("vec%0d_state", i), int'(bus.state), int'(vecs[i].st));
      chk($sformatf("vec%0d_lock", i), int'(bus.lock), int'(vecs[i].lk));
      chk($sformatf("vec%0d_cnt", i), int'(bus.digit_cnt), int'(vecs[i].cnt));
      chk($sformatf("vec%0d_fail", i), int'(bus.fail_cnt), int'(vecs[i].fl));
    end
    bus.tenkey = '0;
    bus.enter  = 1'b0;
    bus.close  = 1'b0;

    // Over-length entry keeps the last four digits
    do_reset();
    press(1);
    press(5);
    press(9);
    press(6);
    press(3);
    chk("long_cnt", int'(bus.digit_cnt), 4);
    pulse(0);
    chk("long_state", int'(bus.state), int'(OPEN));
    chk("long_lock", int'(bus.lock), 0);
    pulse(1);
    chk("close_lock", int'(bus.lock), 1);

    // Lockout after MAX_FAIL bad entries
    for (int k = 1; k <= MAX_FAIL; k++) begin
      pin4(1, 1, 1, 1);
      chk($sformatf("lo_fail%0d", k), int'(bus.fail_cnt), k);
    end
    lk_cyc = ev_cyc;
    chk("lo_state", int'(bus.state), int'(LOCKOUT));
    chk("lo_alarm", int'(bus.alarm), 1);
    chk("lo_lock", int'(bus.lock), 1);
    pin4(5, 9, 6, 3);
    pulse(2);
    pulse(1);
    chk("lo_ignore", int'(bus.state), int'(LOCKOUT));
    while (bus.state == LOCKOUT && (cyc - lk_cyc) < LOCKOUT_CYC + 100) @(negedge ck);
    chk("lo_cycles", cyc - lk_cyc, LOCKOUT_CYC);
    chk("lo_end_state", int'(bus.state), int'(IDLE));
    chk("lo_end_alarm", int'(bus.alarm), 0);
    chk("lo_end_fail", int'(bus.fail_cnt), 0);

    // Timeout abandons entry, fail count kept
    press(1);
    pulse(0);
    press(5);
    press(9);
    chk("to_cnt", int'(bus.digit_cnt), 2);
    while (bus.state == ENTRY && (cyc - acc_cyc) < TIMEOUT_CYC + 100) @(negedge ck);
    chk("to_cycles", cyc - acc_cyc, TIMEOUT_CYC);
    chk("to_state", int'(bus.state), int'(IDLE));
    chk("to_cnt0", int'(bus.digit_cnt), 0);
    chk("to_fail", int'(bus.fail_cnt), 1);

    // PIN change
    pin4(5, 9, 6, 3);
    chk("pc_open", int'(bus.state), int'(OPEN));
    chk("pc_fail0", int'(bus.fail_cnt), 0);
    press(8);
    chk("pc_keys_ignored", int'(bus.state), int'(OPEN));
    pulse(2);
    chk("pc_newpin", int'(bus.state), int'(NEWPIN));
    chk("pc_newpin_lock", int'(bus.lock), 0);
    chk("pc_newpin_cnt", int'(bus.digit_cnt), 0);
    pin4(1, 2, 3, 4);
    chk("pc_back_open", int'(bus.state), int'(OPEN));
    pulse(1);
    pin4(5, 9, 6, 3);
    chk("pc_old_fail", int'(bus.fail_cnt), 1);
    chk("pc_old_lock", int'(bus.lock), 1);
    pin4(1, 2, 3, 4);
    chk("pc_new_open", int'(bus.lock), 0);

    // enter and close together: close wins
    pulse(1);
    press(1);
    press(2);
    press(3);
    press(4);
    bus.enter = 1'b1;
    bus.close = 1'b1;
    @(negedge ck);
    bus.enter = 1'b0;
    bus.close = 1'b0;
    chk("prio_state", int'(bus.state), int'(IDLE));
    chk("prio_lock", int'(bus.lock), 1);
    chk("prio_fail", int'(bus.fail_cnt), 0);

    // Asynchronous reset in NEWPIN restores the default PIN
    pin4(1, 2, 3, 4);
    pulse(2);
    press(7);
    press(7);
    chk("np_cnt", int'(bus.digit_cnt), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_lock", int'(bus.lock), 1);
    chk("arst_state", int'(bus.state), int'(IDLE));
    chk("arst_cnt", int'(bus.digit_cnt), 0);
    @(negedge ck);
    reset_n = 1'b1;
    pin4(5, 9, 6, 3);
    chk("arst_default_pin", int'(bus.state), int'(OPEN));

    // Randomized operations against the transaction-level model
    do_reset();
    m_init();
    for (int i = 0; i < 250; i++) begin
      int r;
      int d;
      int a;
      int b;
      r = int'($urandom_range(0, 99));
      if (r < 50) begin
        d = $urandom_range(0, 1) ? m_pin[m_q.size() % 4] : int'($urandom_range(0, 9));
        press(d);
        m_press(d);
      end else if (r < 58) begin
        a = int'($urandom_range(0, 9));
        b = (a + 1 + int'($urandom_range(0, 8))) % 10;
        press_raw((10'd1 << a) | (10'd1 << b), 2);
      end else if (r < 75) begin
        if (m_st == int'(ENTRY) && !m_match() && m_fail == MAX_FAIL - 1) begin
          pulse(1);
          m_close();
        end else begin
          pulse(0);
          m_enter();
        end
      end else if (r < 87) begin
        pulse(1);
        m_close();
      end else begin
        pulse(2);
        m_setpin();
      end
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elelock_ctrl.md
Name: elelock_ctrl

Overview:
- Sequencing controller for the electronic lock.
- Debounces and encodes the ten-key pad, collects 4-digit PIN entries, and compares each against a programmable PIN register.
- Counts failed attempts, enforces an alarm lockout, times out idle entries, and supports PIN change while open.
- Sits between the keypad/door switches and the lock actuator; `lock` drives the actuator directly.

Parameters:
- DEFAULT_PIN, 16'h5963, PIN loaded at reset; 4 BCD digits, [15:12] first-entered.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7).
- TIMEOUT_CYC, 1000, idle cycles in ENTRY/NEWPIN before the entry is abandoned.
- LOCKOUT_CYC, 5000, cycles spent in LOCKOUT.

Ports:
- ck  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tenkey  input  10  raw key switches, one-hot bit i = digit i.
- enter  input  1  confirm key, synchronous single-cycle pulse.
- close  input  1  door-closed/relock request, level.
- setpin  input  1  PIN-change request, pulse.
- lock  output  1  1 = locked.
- alarm  output  1  1 while in LOCKOUT.
- state  output  3  current FSM state, for debug.
- digit_cnt  output  3  digits held in the entry buffer (0..4).
- fail_cnt  output  3  consecutive failures.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, lock=1, alarm=0, digit_cnt=0, fail_cnt=0.
  - Entry buffer = 4'hF in every digit; pin_reg = DEFAULT_PIN; timers = 0.
  - Reset mid-operation discards the partial entry and any pending PIN change. pin_reg returns to DEFAULT_PIN.
- Key input path:
  - ke1 <= |tenkey and ke2 <= ke1. kd <= keyenc(tenkey), sampled on the same edge as ke1.
  - key_evt = ke1 & ~ke2.
  - A key is accepted only if its tenkey value was exactly one-hot; any other pattern gives kd_valid=0 and the event is dropped.
  - Latency: tenkey rises before edge E1; the digit enters the buffer at edge E2.
- States:
  - IDLE: lock=1. key_evt -> ENTRY; the digit is shifted in and digit_cnt=1.
  - ENTRY:
    - key_evt shifts the buffer left, with the new digit in [3:0]. digit_cnt saturates at 4, so the last 4 digits are kept.
    - On enter, if digit_cnt==4 and buf==pin_reg: -> OPEN and fail_cnt=0.
    - On enter otherwise: fail_cnt+1, buffer cleared, -> IDLE. If fail_cnt+1 == MAX_FAIL, go -> LOCKOUT instead.
    - Idle timer reaches TIMEOUT_CYC with no accepted key: -> IDLE, buffer cleared, fail_cnt unchanged.
  - OPEN: lock=0.
    - close=1 -> IDLE.
    - setpin -> NEWPIN, buffer cleared.
    - Keys are ignored.
  - NEWPIN: lock=0. Digits are collected as in ENTRY.
    - enter with digit_cnt==4: pin_reg <= buf, -> OPEN.
    - enter with digit_cnt<4: discard, -> OPEN.
    - Timeout: -> OPEN, pin_reg unchanged.
    - close: -> IDLE, pin_reg unchanged.
  - LOCKOUT: lock=1, alarm=1. Keys, enter, setpin and close are all ignored. After LOCKOUT_CYC cycles: -> IDLE, fail_cnt=0, alarm=0.
- Priority within one cycle:
  - close beats enter, setpin and key_evt.
  - enter beats key_evt; a coincident key_evt is dropped.
  - close while in IDLE or ENTRY clears the buffer and stays in/returns to IDLE, with no failure counted.
- Timing:
  - lock and alarm are registered and decoded from the next state, so they change on the same edge as the state.
  - Example: enter sampled at edge N gives lock=0 after edge N.
  - The idle timer reloads on every accepted key and on every state change.
- Widths: fail_cnt never exceeds MAX_FAIL. Timers are $clog2(max(TIMEOUT_CYC, LOCKOUT_CYC)+1) bits and never wrap.

Decomposition:
- Package elelock_pkg holds:
  - state enum: IDLE=0, ENTRY=1, OPEN=2, NEWPIN=3, LOCKOUT=4;
  - function keyenc (one-hot to 4-bit digit plus valid flag);
  - the constant BLANK_DIGIT = 4'hF.
- Sub-module elelock_keyin holds the ke1/ke2 flops, the kd register and the encoder. Its outputs are key_evt, digit[3:0] and kd_valid.

Test Plan:
- Correct PIN: after reset, press 5,9,6,3 then enter -> lock=0 one edge after enter; fail_cnt=0; close=1 -> lock=1 next edge.
- Lockout: 3 entries of 1,1,1,1 + enter -> fail_cnt reaches 1 then 2. On the 3rd: state=LOCKOUT, alarm=1. Correct PIN is ignored for 5000 cycles, then IDLE, alarm=0, fail_cnt=0.
- Over-length entry and bad input:
  - Press 1,5,9,6,3 + enter -> opens, since the last 4 digits are kept.
  - tenkey=10'b0000100001 in the stream -> digit_cnt unchanged.
- Timeout: press 5,9, wait 1000 idle cycles -> state=IDLE, digit_cnt=0, fail_cnt unchanged.
- PIN change:
  - While OPEN: setpin, then 1,2,3,4 + enter -> OPEN.
  - close, then 5,9,6,3 + enter -> fail_cnt=1, still locked.
  - 1,2,3,4 + enter -> opens.
- Priority and reset:
  - enter and close in the same cycle during ENTRY with the correct PIN -> IDLE, lock stays 1.
  - reset_n low mid-NEWPIN -> lock=1 immediately and pin_reg=16'h5963.
